animation_sequencer: RTL and testbench
======================================

ANIMATION_SEQUENCER -- requirements
Module: animation_sequencer

Interface
REQ-001 Parameter BANK_LIMIT, default 9, number of star ROM banks (animation phases).
REQ-002 Parameter GUARD_LIMIT, default 16, CLK cycles to wait for LCD_BUSY to rise after LCD_UPDATE.
REQ-003 CLK  in  1  system clock (100 MHz domain).
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 ENABLE  in  1  run animation; 0 = stop after current frame.
REQ-006 FRAME_LIMIT  in  32  frame period in CLK cycles.
REQ-007 BLINK_FRAMES  in  8  frames per eye-layer blink half-period; 0 = no blink.
REQ-008 MIX_START  out  1  one-cycle pulse that starts one layer_mixer render pass.
REQ-009 MIX_DONE  in  1  one-cycle pulse from layer_mixer: render pass complete.
REQ-010 LCD_UPDATE  out  1  one-cycle pulse to st7789 UPDATE.
REQ-011 LCD_BUSY  in  1  st7789 transfer in progress.
REQ-012 BANK  out  $clog2(BANK_LIMIT)  current star ROM bank.
REQ-013 LAYER_CONTROL  out  4  layer enables: [0] star, [1] abdulov, [2] eyes, [3] text.
REQ-014 FRAME_COUNT  out  16  completed frames, wraps at 65535->0.
REQ-015 OVERRUN_COUNT  out  8  frame ticks missed while busy, saturates at 255.

Function
REQ-016 Frame timer: free-running counter 0..max(FRAME_LIMIT,2)-1, wraps to 0; "tick" asserted for the one cycle the counter equals the top value; FRAME_LIMIT 0 or 1 treated as 2.
REQ-017 FSM states: IDLE, WAIT_TICK, MIX, MIX_WAIT, PUSH, PUSH_WAIT, ADVANCE.
REQ-018 IDLE: on ENABLE=1 go to WAIT_TICK next cycle; otherwise stay.
REQ-019 WAIT_TICK: on tick with ENABLE=1 go to MIX; on ENABLE=0 go to IDLE.
REQ-020 MIX: MIX_START=1 for exactly this one cycle; next state MIX_WAIT.
REQ-021 MIX_WAIT: wait indefinitely for MIX_DONE=1, then PUSH; MIX_DONE in any other state is ignored.
REQ-022 PUSH: LCD_UPDATE=1 for exactly this one cycle; next state PUSH_WAIT; guard counter cleared.
REQ-023 PUSH_WAIT: record LCD_BUSY rising; leave to ADVANCE when LCD_BUSY=0 after a recorded rise, or when GUARD_LIMIT cycles elapse with no rise.
REQ-024 ADVANCE: one cycle; BANK = (BANK+1) mod BANK_LIMIT (BANK_LIMIT-1 wraps to 0); FRAME_COUNT+1; blink update; next state WAIT_TICK if ENABLE=1, else IDLE.
REQ-025 Blink: frame counter 0..BLINK_FRAMES-1 advanced in ADVANCE; on wrap LAYER_CONTROL[2] toggles; BLINK_FRAMES=0 forces LAYER_CONTROL[2]=1 and holds blink counter at 0.
REQ-026 LAYER_CONTROL[0],[1],[3] = 1 at all times out of reset.
REQ-027 BANK and LAYER_CONTROL change only in ADVANCE, so they are stable from MIX through PUSH_WAIT.
REQ-028 Overrun: tick occurring in MIX, MIX_WAIT, PUSH, PUSH_WAIT or ADVANCE increments OVERRUN_COUNT (saturating) and is not queued.
REQ-029 ENABLE deasserted mid-frame does not abort: frame completes through ADVANCE, then IDLE.
REQ-030 All outputs registered; MIX_START/LCD_UPDATE never both high in one cycle.

Reset
REQ-031 RESET=1 asynchronously forces: state IDLE, timer 0, MIX_START=0, LCD_UPDATE=0, BANK=0, LAYER_CONTROL=4'b1111, FRAME_COUNT=0, OVERRUN_COUNT=0, blink counter 0, guard counter 0.
REQ-032 RESET asserted mid-frame abandons the frame; no pulse is emitted in the cycle after RESET deasserts.

Verification
REQ-033 FRAME_LIMIT=100, ENABLE=1, MIX_DONE 10 cycles after MIX_START, LCD_BUSY high 20 cycles after LCD_UPDATE -> MIX_START every 100 cycles, one LCD_UPDATE per MIX_DONE, BANK 0..8 then 0, OVERRUN_COUNT=0.
REQ-034 FRAME_LIMIT=20, LCD_BUSY high 50 cycles per frame -> OVERRUN_COUNT increments per missed tick, saturates at 255, FRAME_COUNT still advances once per completed frame.
REQ-035 BLINK_FRAMES=3 -> LAYER_CONTROL[2] pattern 1,1,1,0,0,0,1... across frames; BLINK_FRAMES=0 -> constant 1.
REQ-036 LCD_BUSY held 0 after LCD_UPDATE -> ADVANCE entered exactly GUARD_LIMIT(16) cycles after PUSH_WAIT entry.
REQ-037 ENABLE dropped in MIX_WAIT -> frame completes, FRAME_COUNT+1, then IDLE, no further MIX_START.
REQ-038 RESET pulsed in PUSH_WAIT -> all outputs at REQ-031 values immediately; with ENABLE=1 sequence restarts, first MIX_START at first tick.

Source files
------------

// File: rtl/animation_sequencer.sv
// Frame sequencer: paces one layer_mixer render pass and one st7789 push per frame tick,
// then advances the star bank, frame/blink counters and records ticks missed while busy.
module animation_sequencer #(
    parameter int BANK_LIMIT  = 9,
    parameter int GUARD_LIMIT = 16
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          ENABLE,
    input  logic [31:0]                   FRAME_LIMIT,
    input  logic [7:0]                    BLINK_FRAMES,
    output logic                          MIX_START,
    input  logic                          MIX_DONE,
    output logic                          LCD_UPDATE,
    input  logic                          LCD_BUSY,
    output logic [$clog2(BANK_LIMIT)-1:0] BANK,
    output logic [3:0]                    LAYER_CONTROL,
    output logic [15:0]                   FRAME_COUNT,
    output logic [7:0]                    OVERRUN_COUNT
);
    localparam int BANK_W  = $clog2(BANK_LIMIT);
    localparam int GUARD_W = $clog2(GUARD_LIMIT + 1);
    localparam logic [BANK_W-1:0]  BANK_LAST  = BANK_W'(BANK_LIMIT - 1);
    localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_LIMIT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_MIX, S_MIX_WAIT, S_PUSH, S_PUSH_WAIT, S_ADVANCE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_timer;
    logic [31:0]        w_timer_top;
    logic               w_tick;
    logic               w_frame_busy;
    logic [GUARD_W-1:0] r_guard;
    logic               r_busy_seen;
    logic               w_push_done;
    logic               r_mix_start;
    logic               r_lcd_update;
    logic [BANK_W-1:0]  r_bank;
    logic [7:0]         r_blink_cnt;
    logic               r_eyes;
    logic [15:0]        r_frame_count;
    logic [7:0]         r_overrun_count;

    // Periods below 2 would make the tick a constant; clamp so the counter always cycles.
    assign w_timer_top = (FRAME_LIMIT < 32'd2) ? 32'd1 : FRAME_LIMIT - 32'd1;
    assign w_tick      = (r_timer == w_timer_top);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_timer <= '0;
        end else if (r_timer >= w_timer_top) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    // A rise seen this very cycle must also block the timeout.
    assign w_push_done = r_busy_seen ? !LCD_BUSY
                                     : (!LCD_BUSY && (r_guard == GUARD_LAST));

    // NOTE: next state is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:      if (ENABLE) w_next_state = S_WAIT_TICK;
            S_WAIT_TICK: begin
                if (!ENABLE)     w_next_state = S_IDLE;
                else if (w_tick) w_next_state = S_MIX;
            end
            S_MIX:       w_next_state = S_MIX_WAIT;
            S_MIX_WAIT:  if (MIX_DONE) w_next_state = S_PUSH;
            S_PUSH:      w_next_state = S_PUSH_WAIT;
            S_PUSH_WAIT: if (w_push_done) w_next_state = S_ADVANCE;
            S_ADVANCE:   w_next_state = ENABLE ? S_WAIT_TICK : S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= S_IDLE;
            r_mix_start  <= 1'b0;
            r_lcd_update <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_mix_start  <= (w_next_state == S_MIX);
            r_lcd_update <= (w_next_state == S_PUSH);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_guard     <= '0;
            r_busy_seen <= 1'b0;
        end else if (r_state == S_PUSH) begin
            r_guard     <= '0;
            r_busy_seen <= 1'b0;
        end else if (r_state == S_PUSH_WAIT) begin
            if (r_guard != GUARD_LAST) r_guard <= r_guard + GUARD_W'(1);
            if (LCD_BUSY)              r_busy_seen <= 1'b1;
        end
    end

    assign w_frame_busy = (r_state != S_IDLE) && (r_state != S_WAIT_TICK);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_overrun_count <= '0;
        end else if (w_tick && w_frame_busy && (r_overrun_count != 8'hFF)) begin
            r_overrun_count <= r_overrun_count + 8'd1;
        end
    end

    // Bank, eyes and frame count move only here, keeping them stable for the whole render/push.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_bank        <= '0;
            r_frame_count <= '0;
            r_blink_cnt   <= '0;
            r_eyes        <= 1'b1;
        end else if (r_state == S_ADVANCE) begin
            r_bank        <= (r_bank >= BANK_LAST) ? '0 : r_bank + BANK_W'(1);
            r_frame_count <= r_frame_count + 16'd1;
            if (BLINK_FRAMES == 8'd0) begin
                r_blink_cnt <= '0;
                r_eyes      <= 1'b1;
            end else if (r_blink_cnt >= BLINK_FRAMES - 8'd1) begin
                r_blink_cnt <= '0;
                r_eyes      <= ~r_eyes;
            end else begin
                r_blink_cnt <= r_blink_cnt + 8'd1;
            end
        end
    end

    assign MIX_START     = r_mix_start;
    assign LCD_UPDATE    = r_lcd_update;
    assign BANK          = r_bank;
    assign LAYER_CONTROL = {1'b1, r_eyes, 2'b11};
    assign FRAME_COUNT   = r_frame_count;
    assign OVERRUN_COUNT = r_overrun_count;

endmodule

// File: tb/tb_animation_sequencer.sv
// Bench for animation_sequencer: a frame-schedule model predicts every output each cycle,
// with literal expectations for the fixed-timing scenarios.
module tb_animation_sequencer;
    localparam int BANK_LIMIT  = 9;
    localparam int GUARD_LIMIT = 16;
    localparam int BANK_W      = $clog2(BANK_LIMIT);

    logic              CLK          = 1'b0;
    logic              RESET        = 1'b1;
    logic              ENABLE       = 1'b0;
    logic [31:0]       FRAME_LIMIT  = 32'd100;
    logic [7:0]        BLINK_FRAMES = 8'd0;
    logic              MIX_DONE     = 1'b0;
    logic              LCD_BUSY     = 1'b0;
    logic              MIX_START;
    logic              LCD_UPDATE;
    logic [BANK_W-1:0] BANK;
    logic [3:0]        LAYER_CONTROL;
    logic [15:0]       FRAME_COUNT;
    logic [7:0]        OVERRUN_COUNT;

    animation_sequencer #(.BANK_LIMIT(BANK_LIMIT), .GUARD_LIMIT(GUARD_LIMIT)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FRAME_LIMIT(FRAME_LIMIT),
        .BLINK_FRAMES(BLINK_FRAMES), .MIX_START(MIX_START), .MIX_DONE(MIX_DONE),
        .LCD_UPDATE(LCD_UPDATE), .LCD_BUSY(LCD_BUSY), .BANK(BANK),
        .LAYER_CONTROL(LAYER_CONTROL), .FRAME_COUNT(FRAME_COUNT), .OVERRUN_COUNT(OVERRUN_COUNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: sequencer is idle, armed for the next tick, or inside a scheduled frame.
    typedef enum {M_IDLE, M_ARMED, M_FRAME} mode_t;
    mode_t m_mode;
    int    m_period, m_blink, m_frames, m_overruns;
    int    f_mix, f_done, f_upd, f_adv, f_d, f_b;
    bit    f_rise;

    int k_lat_min, k_lat_max, k_rise_pct, k_d_max, k_b_min, k_b_max, k_en_mode;
    bit k_spurious, k_en_val;

    int          mix_cyc[$];
    int          mix_bank[$];
    int          mix_eye[$];
    int          fc_change[$];
    int          upd_cnt;
    logic [15:0] fc_prev;

    function automatic int qget(input int q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return -1;
    endfunction

    task automatic set_knobs(input int lat_min, input int lat_max, input int rise_pct,
                             input int d_max, input int b_min, input int b_max,
                             input bit spurious, input int en_mode);
        k_lat_min = lat_min; k_lat_max = lat_max; k_rise_pct = rise_pct;
        k_d_max = d_max; k_b_min = b_min; k_b_max = b_max;
        k_spurious = spurious; k_en_mode = en_mode; k_en_val = 1'b1;
    endtask

    // Whole frame timeline is fixed the moment its tick is consumed.
    task automatic plan_frame();
        f_mix  = cyc + 1;
        f_done = f_mix + int'($urandom_range(k_lat_max, k_lat_min));
        f_upd  = f_done + 1;
        f_rise = ($urandom_range(99) < k_rise_pct);
        f_d    = $urandom_range(k_d_max, 1);
        f_b    = $urandom_range(k_b_max, k_b_min);
        if (f_b == 0) f_rise = 1'b0;
        f_adv  = f_rise ? f_upd + f_d + f_b + 1 : f_upd + 1 + GUARD_LIMIT;
    endtask

    task automatic step();
        bit eye, en, done, busy, tick, in_mix_wait;
        eye = (m_blink == 0) || (((m_frames / m_blink) % 2) == 0);
        check("mix_start", 32'(MIX_START), 32'(m_mode == M_FRAME && cyc == f_mix));
        check("lcd_update", 32'(LCD_UPDATE), 32'(m_mode == M_FRAME && cyc == f_upd));
        check("bank", 32'(BANK), 32'(m_frames % BANK_LIMIT));
        check("layer_control", 32'(LAYER_CONTROL), 32'({1'b1, eye, 2'b11}));
        check("frame_count", 32'(FRAME_COUNT), 32'(m_frames % 65536));
        check("overrun_count", 32'(OVERRUN_COUNT), 32'(m_overruns));
        if (MIX_START === 1'b1) begin
            mix_cyc.push_back(cyc);
            mix_bank.push_back(int'(BANK));
            mix_eye.push_back(int'(LAYER_CONTROL[2]));
        end
        if (LCD_UPDATE === 1'b1) upd_cnt++;
        if (FRAME_COUNT !== fc_prev) begin
            fc_change.push_back(cyc);
            fc_prev = FRAME_COUNT;
        end

        en          = (k_en_mode == 0) ? k_en_val : ($urandom_range(19) != 0);
        in_mix_wait = (m_mode == M_FRAME) && (cyc > f_mix) && (cyc <= f_done);
        done = (m_mode == M_FRAME && cyc == f_done) ||
               (k_spurious && !in_mix_wait && $urandom_range(7) == 0);
        busy = (m_mode == M_FRAME) && f_rise && (cyc >= f_upd + f_d) && (cyc < f_upd + f_d + f_b);
        ENABLE   = en;
        MIX_DONE = done;
        LCD_BUSY = busy;

        tick = ((cyc % m_period) == m_period - 1);
        case (m_mode)
            M_IDLE:  if (en) m_mode = M_ARMED;
            M_ARMED: begin
                if (!en) m_mode = M_IDLE;
                else if (tick) begin
                    plan_frame();
                    m_mode = M_FRAME;
                end
            end
            default: begin
                if (tick && m_overruns < 255) m_overruns++;
                if (cyc == f_adv) begin
                    m_frames++;
                    m_mode = en ? M_ARMED : M_IDLE;
                end
            end
        endcase
        @(negedge CLK);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int period, input int blink, input bit check_now);
        RESET = 1'b1;
        if (check_now) begin
            #1;
            check("reset_mix_start", 32'(MIX_START), 32'd0);
            check("reset_lcd_update", 32'(LCD_UPDATE), 32'd0);
            check("reset_bank", 32'(BANK), 32'd0);
            check("reset_layer_control", 32'(LAYER_CONTROL), 32'hF);
            check("reset_frame_count", 32'(FRAME_COUNT), 32'd0);
            check("reset_overrun_count", 32'(OVERRUN_COUNT), 32'd0);
        end
        ENABLE       = 1'b0;
        MIX_DONE     = 1'b0;
        LCD_BUSY     = 1'b0;
        FRAME_LIMIT  = 32'(period);
        BLINK_FRAMES = 8'(blink);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        #1;
        cyc        = 0;
        m_mode     = M_IDLE;
        m_period   = (period < 2) ? 2 : period;
        m_blink    = blink;
        m_frames   = 0;
        m_overruns = 0;
        f_mix = -10; f_done = -10; f_upd = -10; f_adv = -10; f_rise = 1'b0;
        mix_cyc.delete(); mix_bank.delete(); mix_eye.delete(); fc_change.delete();
        upd_cnt = 0;
        fc_prev = 16'd0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Steady 100-cycle frames: one pulse pair per frame, bank walks 0..8 then wraps.
        set_knobs(10, 10, 100, 1, 20, 20, 1'b0, 0);
        do_reset(100, 0, 1'b0);
        run(1100);
        check("steady_mix_count", 32'(mix_cyc.size()), 32'd10);
        check("steady_first_mix", 32'(qget(mix_cyc, 0)), 32'd100);
        check("steady_second_mix", 32'(qget(mix_cyc, 1)), 32'd200);
        check("steady_tenth_mix", 32'(qget(mix_cyc, 9)), 32'd1000);
        check("steady_bank_last", 32'(qget(mix_bank, 8)), 32'd8);
        check("steady_bank_wrap", 32'(qget(mix_bank, 9)), 32'd0);
        check("steady_update_count", 32'(upd_cnt), 32'd10);
        check("steady_overrun", 32'(OVERRUN_COUNT), 32'd0);

        // Blink half-period of three frames, then blinking disabled.
        set_knobs(2, 2, 100, 1, 3, 3, 1'b0, 0);
        do_reset(30, 3, 1'b0);
        run(240);
        check("blink_mix_count", 32'(mix_cyc.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            int exp_eye;
            exp_eye = (i >= 3 && i <= 5) ? 0 : 1;
            check($sformatf("blink3_frame%0d", i), 32'(qget(mix_eye, i)), 32'(exp_eye));
        end
        do_reset(30, 0, 1'b0);
        run(150);
        check("blink0_mix_count", 32'(mix_cyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("blink0_frame%0d", i), 32'(qget(mix_eye, i)), 32'd1);

        // Display never raises busy: push phase ends on the guard timeout.
        set_knobs(3, 3, 0, 1, 1, 1, 1'b0, 0);
        do_reset(60, 0, 1'b0);
        run(200);
        check("guard_first_mix", 32'(qget(mix_cyc, 0)), 32'd60);
        check("guard_advance_cycle", 32'(qget(fc_change, 0)), 32'd82);

        // Enable dropped while waiting for the mixer: frame completes, then stays idle.
        set_knobs(8, 8, 100, 1, 5, 5, 1'b0, 0);
        do_reset(50, 0, 1'b0);
        for (int i = 0; i < 500 && !(m_mode == M_FRAME && cyc == f_mix + 1); i++) step();
        check("stop_reached_mix_wait", 32'(m_mode == M_FRAME && cyc == f_mix + 1), 32'd1);
        k_en_val = 1'b0;
        run(300);
        check("stop_frame_count", 32'(FRAME_COUNT), 32'd1);
        check("stop_mix_count", 32'(mix_cyc.size()), 32'd1);

        // Reset during the push phase of the fourth frame, then restart.
        set_knobs(3, 3, 100, 1, 30, 30, 1'b0, 0);
        do_reset(20, 1, 1'b0);
        for (int i = 0; i < 2000 && !(m_frames == 3 && m_mode == M_FRAME && cyc == f_upd + 1); i++)
            step();
        check("midreset_reached_push_wait", 32'(m_frames == 3 && m_mode == M_FRAME && cyc == f_upd + 1), 32'd1);
        check("midreset_bank_before", 32'(BANK), 32'd3);
        do_reset(20, 1, 1'b1);
        run(100);
        check("midreset_first_mix", 32'(qget(mix_cyc, 0)), 32'd20);

        // Display busy longer than the frame period: overruns pile up and saturate.
        set_knobs(2, 2, 100, 1, 50, 50, 1'b0, 0);
        do_reset(20, 0, 1'b0);
        run(8000);
        check("overrun_saturated", 32'(OVERRUN_COUNT), 32'd255);

        // Randomised periods, latencies, busy shapes, enable drops and stray MIX_DONE pulses.
        for (int r = 0; r < 3; r++) begin
            int sel;
            int per;
            sel = $urandom_range(5);
            per = (sel == 0) ? 0 : (sel == 1) ? 1 : int'($urandom_range(90, 3));
            set_knobs(1, 12, 75, GUARD_LIMIT, 0, 40, 1'b1, 1);
            do_reset(per, int'($urandom_range(4)), 1'b0);
            run(1500);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
